// File: rtl/fft_pitch_pkg.sv
// Shared types and helpers for the FFT pitch tracker.
package fft_pitch_pkg;

    localparam int          MAG_W     = 33;
    localparam int          BIN_W     = 10;
    localparam int unsigned DEF_K_MIN = 2;
    localparam int unsigned DEF_K_MAX = 511;

    // Field widths follow the default W/KW of fft_pitch_tracker.
    typedef struct packed {
        logic [BIN_W-1:0] k;
        logic [MAG_W-1:0] mag;
        logic             silent;
    } pitch_result_t;

    function automatic logic in_band(input int unsigned k,
                                     input int unsigned k_min,
                                     input int unsigned k_max);
        return (k >= k_min) && (k <= k_max);
    endfunction

endpackage

// File: rtl/pitch_history_avg.sv
// Ring buffer of the last 2**AVG_LOG2 pitch bins with a running sum.
// out_k is the value to present for the current push (0 on clear).
module pitch_history_avg #(
    parameter int KW       = 10,
    parameter int AVG_LOG2 = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [KW-1:0] k_in,
    output logic [KW-1:0] out_k
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = KW + AVG_LOG2;
    localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int RD    = 1 << PW;
    localparam int FW    = AVG_LOG2 + 1;

    logic [KW-1:0] ring_q [RD];
    logic [KW-1:0] ring_d [RD];
    logic [PW-1:0] wr_q, wr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [KW-1:0] evicted;
    logic          full;

    // Until the ring is full nothing is evicted, so stale slots never reach the sum.
    always_comb begin
        full    = (fill_q == FW'(DEPTH));
        evicted = full ? ring_q[wr_q] : '0;
        ring_d  = ring_q;
        wr_d    = wr_q;
        fill_d  = fill_q;
        sum_d   = sum_q;
        out_k   = '0;
        if (clear) begin
            wr_d   = '0;
            fill_d = '0;
            sum_d  = '0;
        end else if (push) begin
            ring_d[wr_q] = k_in;
            wr_d         = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            fill_d       = full ? fill_q : fill_q + 1'b1;
            sum_d        = sum_q + SW'(k_in) - SW'(evicted);
            out_k        = (fill_d == FW'(DEPTH)) ? KW'(sum_d >> AVG_LOG2) : k_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD; i++) ring_q[i] <= '0;
            wr_q   <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else begin
            ring_q <= ring_d;
            wr_q   <= wr_d;
            fill_q <= fill_d;
            sum_q  <= sum_d;
        end
    end

endmodule

// File: rtl/fft_pitch_tracker.sv
// Per-frame peak-bin pitch tracker with silence gating, smoothing and a valid/ready output.
// Define FFT_PITCH_HYST_EN to suppress results within HYST_BINS of the last delivered pitch.
module fft_pitch_tracker
    import fft_pitch_pkg::*;
#(
    parameter int          W         = MAG_W,
    parameter int          NSAMPLES  = 1024,
    parameter int          KW        = $clog2(NSAMPLES),
    parameter int unsigned K_MIN     = DEF_K_MIN,
    parameter int unsigned K_MAX     = DEF_K_MAX,
    parameter int          AVG_LOG2  = 2,
    parameter int unsigned HYST_BINS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  mag,
    input  logic          mag_valid,
    input  logic          mag_sof,
    input  logic [W-1:0]  cfg_threshold,
    output logic [KW-1:0] pitch_k,
    output logic [W-1:0]  pitch_mag,
    output logic          pitch_silent,
    output logic          pitch_valid,
    input  logic          pitch_ready,
    output logic          pitch_overrun
);

`ifdef FFT_PITCH_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    logic [KW-1:0] k_q, k_d, cur_idx, base_k, peak_k_q, peak_k_d;
    logic [W-1:0]  base_mag, peak_mag_q, peak_mag_d;
    logic          frame_start, eof_q, eof_d;
    logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    pitch_result_t s1_q, s1_d, s2_q, s2_d, out_q, out_d;
    logic          pitch_valid_q, pitch_valid_d, overrun_q, overrun_d;
    logic [KW-1:0] last_k_q, last_k_d, k_diff, hist_k;
    logic          have_last_q, have_last_d;
    logic          hist_clear, hist_push, suppress, load;

    // Bin 0 (counted or forced by sof) restarts the search, discarding any partial frame.
    always_comb begin
        cur_idx     = mag_sof ? '0 : k_q;
        frame_start = (cur_idx == '0);
        base_mag    = frame_start ? '0 : peak_mag_q;
        base_k      = frame_start ? KW'(K_MIN) : peak_k_q;
        k_d         = k_q;
        peak_k_d    = peak_k_q;
        peak_mag_d  = peak_mag_q;
        eof_d       = 1'b0;
        if (mag_valid) begin
            k_d        = cur_idx + 1'b1;
            peak_k_d   = base_k;
            peak_mag_d = base_mag;
            if (in_band(32'(cur_idx), K_MIN, K_MAX) && (mag > base_mag)) begin
                peak_k_d   = cur_idx;
                peak_mag_d = mag;
            end
            eof_d = (cur_idx == KW'(NSAMPLES - 1));
        end
    end

    pitch_history_avg #(
        .KW       (KW),
        .AVG_LOG2 (AVG_LOG2)
    ) u_hist (
        .clk   (clk),
        .reset (reset),
        .clear (hist_clear),
        .push  (hist_push),
        .k_in  (s1_q.k),
        .out_k (hist_k)
    );

    always_comb begin
        s1_valid_d = eof_q;
        s1_d       = s1_q;
        if (eof_q) begin
            s1_d.k      = peak_k_q;
            s1_d.mag    = peak_mag_q;
            s1_d.silent = (peak_mag_q < cfg_threshold);
        end

        hist_clear = s1_valid_q && s1_q.silent;
        hist_push  = s1_valid_q && !s1_q.silent;
        s2_valid_d = s1_valid_q;
        s2_d       = s2_q;
        if (s1_valid_q) begin
            s2_d.k      = hist_k;
            s2_d.mag    = s1_q.mag;
            s2_d.silent = s1_q.silent;
        end

        k_diff      = (s2_q.k >= last_k_q) ? s2_q.k - last_k_q : last_k_q - s2_q.k;
        suppress    = HYST_EN && !s2_q.silent && have_last_q && (32'(k_diff) <= HYST_BINS);
        load        = s2_valid_q && !suppress;
        last_k_d    = last_k_q;
        have_last_d = have_last_q;
        if (load) begin
            last_k_d    = s2_q.k;
            have_last_d = !s2_q.silent;
        end

        // A load in the same cycle as a transfer replaces the result without counting as overrun.
        out_d         = out_q;
        pitch_valid_d = pitch_valid_q;
        overrun_d     = overrun_q;
        if (pitch_valid_q && pitch_ready) pitch_valid_d = 1'b0;
        if (load) begin
            out_d         = s2_q;
            pitch_valid_d = 1'b1;
            if (pitch_valid_q && !pitch_ready) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q           <= '0;
            peak_k_q      <= '0;
            peak_mag_q    <= '0;
            eof_q         <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_q          <= '0;
            s2_valid_q    <= 1'b0;
            s2_q          <= '0;
            out_q         <= '0;
            pitch_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            last_k_q      <= '0;
            have_last_q   <= 1'b0;
        end else begin
            k_q           <= k_d;
            peak_k_q      <= peak_k_d;
            peak_mag_q    <= peak_mag_d;
            eof_q         <= eof_d;
            s1_valid_q    <= s1_valid_d;
            s1_q          <= s1_d;
            s2_valid_q    <= s2_valid_d;
            s2_q          <= s2_d;
            out_q         <= out_d;
            pitch_valid_q <= pitch_valid_d;
            overrun_q     <= overrun_d;
            last_k_q      <= last_k_d;
            have_last_q   <= have_last_d;
        end
    end

    assign pitch_k       = out_q.k;
    assign pitch_mag     = out_q.mag;
    assign pitch_silent  = out_q.silent;
    assign pitch_valid   = pitch_valid_q;
    assign pitch_overrun = overrun_q;

endmodule

// File: tb/tb_fft_pitch_tracker.sv
// Self-checking bench for fft_pitch_tracker: directed vector table, corner sequences, random frames vs model.
module tb_fft_pitch_tracker;

    localparam int          W         = 33;
    localparam int          NS        = 1024;
    localparam int          KW        = 10;
    localparam int unsigned K_MIN     = 2;
    localparam int unsigned K_MAX     = 511;
    localparam int          AVG_LOG2  = 2;
    localparam int          DEPTH     = 1 << AVG_LOG2;
    localparam int          HYST_BINS = 1;
    localparam int          NVEC      = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  mag;
    logic          mag_valid, mag_sof;
    logic [W-1:0]  cfg_threshold;
    logic [KW-1:0] pitch_k;
    logic [W-1:0]  pitch_mag;
    logic          pitch_silent, pitch_valid, pitch_ready, pitch_overrun;

    always #5 clk = ~clk;

    fft_pitch_tracker #(
        .W(W), .NSAMPLES(NS), .KW(KW), .K_MIN(K_MIN), .K_MAX(K_MAX),
        .AVG_LOG2(AVG_LOG2), .HYST_BINS(HYST_BINS)
    ) dut (
        .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid), .mag_sof(mag_sof),
        .cfg_threshold(cfg_threshold), .pitch_k(pitch_k), .pitch_mag(pitch_mag),
        .pitch_silent(pitch_silent), .pitch_valid(pitch_valid), .pitch_ready(pitch_ready),
        .pitch_overrun(pitch_overrun)
    );

    typedef struct {
        int bg;
        int b1, v1, b2, v2, b3, v3;
        int thr;
        int ek, emag;
        bit esil;
    } vec_t;

    typedef struct {
        int           k;
        logic [W-1:0] mag;
        bit           silent;
    } exp_t;

    vec_t         tbl [NVEC];
    exp_t         exp_q [$];
    int           hist [$];
    int           last_k;
    bit           have_last;
    logic [W-1:0] fr [NS];
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 0, rand_ready = 0, gap_en = 0, seen_valid = 0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pitch_valid) seen_valid = 1;
        if (rand_ready) pitch_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_bins(input int from, input int upto, input logic [W-1:0] thr, input bit sof_first);
        for (int i = from; i < upto; i++) begin
            if (gap_en) begin
                while ($urandom_range(0, 15) == 0) begin
                    mag       = W'($urandom);
                    mag_valid = 1'b0;
                    mag_sof   = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            mag       = fr[i];
            mag_valid = 1'b1;
            mag_sof   = (i == from) && sof_first;
            if (i == 1) cfg_threshold = thr;
            tick();
        end
        mag_valid = 1'b0;
        mag_sof   = 1'b0;
    endtask

    task automatic one_peak(input int bg, input int b, input int v);
        for (int i = 0; i < NS; i++) fr[i] = W'(bg);
        fr[b] = W'(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        for (int i = 0; i < NS; i++) fr[i] = W'(v.bg);
        fr[v.b3] = W'(v.v3);
        fr[v.b2] = W'(v.v2);
        fr[v.b1] = W'(v.v1);
        send_bins(0, NS, W'(v.thr), 1'b1);
    endtask

    task automatic wait_result(input string tag, input int ek, input logic [W-1:0] emag, input bit esil);
        int cyc;
        cyc = 0;
        while (!pitch_valid && cyc < 8) begin
            tick();
            cyc++;
        end
        check_output({tag, "_latency"}, 64'(cyc), 64'(3));
        check_output({tag, "_k"}, 64'(pitch_k), 64'(ek));
        check_output({tag, "_mag"}, 64'(pitch_mag), 64'(emag));
        check_output({tag, "_silent"}, 64'(pitch_silent), 64'(esil));
        tick();
        check_output({tag, "_drop"}, 64'(pitch_valid), 64'(0));
    endtask

    // Reference: max in band, lowest index of that max, mean of the last DEPTH non-silent peaks.
    task automatic model_frame(input logic [W-1:0] thr);
        logic [W-1:0] maxv;
        int           pk, sum, d;
        exp_t         e;
        maxv = '0;
        for (int i = int'(K_MIN); i <= int'(K_MAX); i++) if (fr[i] > maxv) maxv = fr[i];
        pk = int'(K_MIN);
        if (maxv != 0) for (int i = int'(K_MAX); i >= int'(K_MIN); i--) if (fr[i] == maxv) pk = i;
        e.mag    = maxv;
        e.silent = (maxv < thr);
        if (e.silent) begin
            hist.delete();
            e.k = 0;
        end else begin
            hist.push_back(pk);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            sum = 0;
            foreach (hist[j]) sum += hist[j];
            e.k = (hist.size() == DEPTH) ? sum / DEPTH : pk;
        end
        d = (e.k > last_k) ? e.k - last_k : last_k - e.k;
`ifdef FFT_PITCH_HYST_EN
        if (!(!e.silent && have_last && d <= HYST_BINS)) begin
            have_last = !e.silent;
            last_k    = e.k;
            exp_q.push_back(e);
        end
`else
        exp_q.push_back(e);
`endif
    endtask

    task automatic model_send(input logic [W-1:0] thr);
        model_frame(thr);
        send_bins(0, NS, thr, 1'b1);
    endtask

    task automatic rand_frame(output logic [W-1:0] thr);
        int           bgm, b1, b2;
        logic [W-1:0] v;
        bgm = $urandom_range(0, 300);
        for (int i = 0; i < NS; i++) fr[i] = W'($urandom_range(0, bgm));
        case ($urandom_range(0, 3))
            1: fr[$urandom_range(0, NS - 1)] = W'($urandom_range(0, 200000));
            2: begin
                b1 = $urandom_range(K_MIN, K_MAX);
                b2 = $urandom_range(K_MIN, K_MAX);
                v  = W'($urandom_range(400, 200000));
                fr[b1] = v;
                fr[b2] = v;
            end
            3: fr[$urandom_range(K_MIN, K_MAX)] = {1'b1, 32'($urandom)};
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: thr = '0;
            1: thr = W'($urandom_range(0, 300));
            2: thr = W'($urandom_range(0, 200000));
            default: thr = {1'b1, 32'hFFFF_FFFF};
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        hist.delete();
        have_last = 0;
        last_k    = 0;
    endtask

    // Transfers are checked at the falling edge, where valid/ready are stable before the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && reset && pitch_valid && pitch_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mon_unexpected: got k=%0d expected no result", pitch_k);
            end else begin
                e = exp_q.pop_front();
                check_output("mon_k", 64'(pitch_k), 64'(e.k));
                check_output("mon_mag", 64'(pitch_mag), 64'(e.mag));
                check_output("mon_silent", 64'(pitch_silent), 64'(e.silent));
            end
        end
    end

    initial begin
        logic [W-1:0] thr;
        int           cyc;

        tbl[0]  = '{10, 40, 1000, 0, 0, 0, 0, 100, 40, 1000, 0};
        tbl[1]  = '{10, 30, 500, 60, 500, 0, 0, 100, 30, 500, 0};
        tbl[2]  = '{10, 1, 5000, 600, 6000, 100, 300, 100, 100, 300, 0};
        tbl[3]  = '{10, 50, 50, 0, 0, 0, 0, 100, 0, 50, 1};
        tbl[4]  = '{10, 40, 1000, 0, 0, 0, 0, 100, 40, 1000, 0};
        tbl[5]  = '{10, 44, 1000, 0, 0, 0, 0, 100, 44, 1000, 0};
        tbl[6]  = '{10, 48, 1000, 0, 0, 0, 0, 100, 48, 1000, 0};
        tbl[7]  = '{10, 52, 1000, 0, 0, 0, 0, 100, 46, 1000, 0};
        tbl[8]  = '{10, 60, 1000, 0, 0, 0, 0, 100, 51, 1000, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 40, 0, 0};
        tbl[10] = '{0, 511, 7, 512, 9999, 0, 0, 5, 156, 7, 0};
        tbl[11] = '{0, 2, 3, 1, 100, 0, 0, 1, 143, 3, 0};

        reset = 1'b0; mag = '0; mag_valid = 1'b0; mag_sof = 1'b0;
        cfg_threshold = '0; pitch_ready = 1'b1; have_last = 0; last_k = 0;
        repeat (3) tick();
        check_output("rst_k", 64'(pitch_k), 64'(0));
        check_output("rst_mag", 64'(pitch_mag), 64'(0));
        check_output("rst_silent", 64'(pitch_silent), 64'(0));
        check_output("rst_valid", 64'(pitch_valid), 64'(0));
        check_output("rst_overrun", 64'(pitch_overrun), 64'(0));
        reset = 1'b1;
        tick();

        for (int t = 0; t < NVEC; t++) begin
            apply_stimulus(tbl[t]);
            wait_result($sformatf("vec%0d", t), tbl[t].ek, W'(tbl[t].emag), tbl[t].esil);
        end

        $display("[TB] overrun sequence");
        do_reset();
        pitch_ready = 1'b0;
        one_peak(10, 40, 1000);
        send_bins(0, NS, W'(100), 1'b1);
        one_peak(10, 80, 2000);
        send_bins(0, NS, W'(100), 1'b1);
        tick();
        tick();
        check_output("ovr_held_k", 64'(pitch_k), 64'(40));
        check_output("ovr_held_valid", 64'(pitch_valid), 64'(1));
        check_output("ovr_not_yet", 64'(pitch_overrun), 64'(0));
        tick();
        check_output("ovr_new_k", 64'(pitch_k), 64'(80));
        check_output("ovr_new_mag", 64'(pitch_mag), 64'(2000));
        check_output("ovr_valid", 64'(pitch_valid), 64'(1));
        check_output("ovr_flag", 64'(pitch_overrun), 64'(1));
        pitch_ready = 1'b1;
        tick();
        check_output("ovr_drop", 64'(pitch_valid), 64'(0));
        tick();
        check_output("ovr_single", 64'(pitch_valid), 64'(0));
        check_output("ovr_sticky", 64'(pitch_overrun), 64'(1));

        $display("[TB] sof sequence");
        do_reset();
        one_peak(10, 100, 9000);
        send_bins(0, 500, W'(100), 1'b1);
        one_peak(10, 200, 500);
        seen_valid = 0;
        send_bins(0, NS, W'(100), 1'b1);
        check_output("sof_no_partial", 64'(seen_valid), 64'(0));
        wait_result("sof", 200, W'(500), 1'b0);

        $display("[TB] reset mid-frame sequence");
        pitch_ready = 1'b0;
        one_peak(10, 300, 700);
        send_bins(0, NS, W'(100), 1'b1);
        one_peak(10, 250, 800);
        send_bins(0, 700, W'(100), 1'b1);
        check_output("mid_pre_valid", 64'(pitch_valid), 64'(1));
        check_output("mid_pre_k", 64'(pitch_k), 64'(300));
        reset = 1'b0;
        #2;
        check_output("mid_rst_k", 64'(pitch_k), 64'(0));
        check_output("mid_rst_mag", 64'(pitch_mag), 64'(0));
        check_output("mid_rst_valid", 64'(pitch_valid), 64'(0));
        check_output("mid_rst_overrun", 64'(pitch_overrun), 64'(0));
        tick();
        reset = 1'b1;
        pitch_ready = 1'b1;
        seen_valid = 0;
        send_bins(0, NS, W'(100), 1'b1);
        check_output("mid_dropped", 64'(seen_valid), 64'(0));
        wait_result("mid_full", 250, W'(800), 1'b0);

        $display("[TB] hysteresis-window and random sequences");
        do_reset();
        mon_en = 1;
        one_peak(10, 40, 1000);
        model_send(W'(100));
        one_peak(10, 41, 1000);
        model_send(W'(100));
        one_peak(10, 43, 1000);
        model_send(W'(100));
        gap_en = 1;
        rand_ready = 1;
        for (int f = 0; f < 20; f++) begin
            rand_frame(thr);
            model_send(thr);
        end
        gap_en = 0;
        rand_ready = 0;
        pitch_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        check_output("drain_pending", 64'(exp_q.size()), 64'(0));
        check_output("final_overrun", 64'(pitch_overrun), 64'(0));
        mon_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
